// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the serial BCD-to-binary converter.
//   state_t        : ACCUM (collecting digits) / HOLD (result presented)
//   DEF_NUM_DIGITS : default digits per number
//   DEF_BIN_W      : default result width, ceil(log2(10^DEF_NUM_DIGITS))
//   TEN            : decimal radix used by the multiply-accumulate
package bcd_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_BIN_W = 14;
  localparam int TEN = 10;
endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational acc*10 + digit step with optional BCD range check.
//   acc_i   : running binary value
//   digit_i : incoming BCD digit
//   sum_o   : acc_i*10 + digit, truncated to BIN_W bits
//   bad_o   : digit_i is not a BCD digit (only when BCD_RANGE_CHECK_EN is defined, else 0)
// Macro: BCD_RANGE_CHECK_EN -- when defined, digits above 9 contribute 0 and raise bad_o.
import bcd_pkg::*;
module bcd_mac10 #(
  parameter int BIN_W = DEF_BIN_W
) (
  input  logic [BIN_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [BIN_W-1:0] sum_o,
  output logic             bad_o
);
  logic [3:0] d;
`ifdef BCD_RANGE_CHECK_EN
  assign bad_o = digit_i > 4'd9;
`else
  assign bad_o = 1'b0;
`endif
  assign d = bad_o ? 4'd0 : digit_i;
  // Product formed 4 bits wider than the result, then truncated (modulo 2^BIN_W).
  assign sum_o = BIN_W'({4'd0, acc_i} * (BIN_W + 4)'(TEN) + (BIN_W + 4)'(d));
endmodule

// File: rtl/bcd_serial_to_binary.sv
// bcd_serial_to_binary: assembles NUM_DIGITS serial BCD digits (MSD first) into a binary value.
//   clk, rst_n                : rising-edge clock, asynchronous active-low reset
//   digit_in/valid/ready      : upstream digit handshake
//   bin_out/valid/ready       : downstream result handshake
//   bin_err                   : result contained a non-BCD digit
// Macro: BCD_RANGE_CHECK_EN -- enables the non-BCD digit check; otherwise bin_err is 0.
import bcd_pkg::*;
module bcd_serial_to_binary #(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int BIN_W      = DEF_BIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  output logic             digit_ready,
  output logic [BIN_W-1:0] bin_out,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic             bin_err
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  state_t          state_q, state_d;
  logic [BIN_W-1:0] acc_q, acc_d, mac_sum;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d, mac_bad, take, done, last;
  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc_i   (acc_q),
    .digit_i (digit_in),
    .sum_o   (mac_sum),
    .bad_o   (mac_bad)
  );
  assign digit_ready = state_q == ACCUM;
  assign bin_valid   = state_q == HOLD;
  assign bin_out     = acc_q;
  // err_q can only be set when the range check is compiled in, so this is 0 otherwise.
  assign bin_err     = bin_valid && err_q;
  assign take        = digit_ready && digit_valid;
  assign done        = bin_valid && bin_ready;
  assign last        = cnt_q == CW'(NUM_DIGITS - 1);
  always_comb begin
    acc_d   = done ? '0 : take ? mac_sum : acc_q;
    cnt_d   = done ? '0 : take ? cnt_q + CW'(1) : cnt_q;
    err_d   = done ? 1'b0 : take ? (err_q || mac_bad) : err_q;
    state_d = done ? ACCUM : (take && last) ? HOLD : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_bcd_serial_to_binary.sv
// tb_bcd_serial_to_binary: directed self-checking bench for bcd_serial_to_binary.
module tb_bcd_serial_to_binary;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_valid = 1'b0;
  logic        digit_ready;
  logic [13:0] bin_out;
  logic        bin_valid;
  logic        bin_ready = 1'b1;
  logic        bin_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  bcd_serial_to_binary dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .bin_out     (bin_out),
    .bin_valid   (bin_valid),
    .bin_ready   (bin_ready),
    .bin_err     (bin_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a digit after the falling edge; it is taken on the next rising edge.
  task automatic put(input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    while (!digit_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n == 20) check("put_ready_timeout", 0, 1);
    digit_in = d;
    digit_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic send4(input logic [3:0] a, b, c, d);
    put(a); put(b); put(c); put(d);
  endtask

  // Result must be presented the cycle after the last digit and released after one handshake.
  task automatic expect_num(input string tag, input logic [31:0] val, input logic err);
    @(negedge clk);
    digit_valid = 1'b0;
    check({tag, "_valid"}, bin_valid, 1);
    check({tag, "_out"}, bin_out, val);
    check({tag, "_err"}, bin_err, err);
    check({tag, "_dready"}, digit_ready, 0);
    @(negedge clk);
    check({tag, "_valid_drop"}, bin_valid, 0);
    check({tag, "_dready_back"}, digit_ready, 1);
  endtask

  initial begin
    logic [3:0]  seq [8];
    logic [31:0] outs [4];
    int          n_out, gaps, idx;
    @(negedge clk);
    check("rst_out", bin_out, 0);
    check("rst_valid", bin_valid, 0);
    check("rst_err", bin_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_dready", digit_ready, 1);

    send4(1, 2, 3, 4);
    expect_num("n1234", 1234, 0);

    // Stalls between digits must not disturb the accumulation.
    put(9);
    repeat (3) begin
      @(negedge clk);
      digit_valid = 1'b0;
    end
    put(9); put(9); put(9);
    expect_num("n9999", 9999, 0);

    // Downstream back-pressure: result held, digits offered meanwhile are ignored.
    bin_ready = 1'b0;
    send4(0, 0, 0, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      digit_in = 4'd9;
      digit_valid = 1'b1;
      check("hold_valid", bin_valid, 1);
      check("hold_out", bin_out, 7);
      check("hold_dready", digit_ready, 0);
    end
    @(negedge clk);
    digit_valid = 1'b0;
    bin_ready = 1'b1;
    check("hold_out_last", bin_out, 7);
    @(negedge clk);
    check("hold_release_valid", bin_valid, 0);
    check("hold_release_dready", digit_ready, 1);
    check("hold_release_acc", bin_out, 0);
    send4(1, 2, 3, 4);
    expect_num("after_hold", 1234, 0);

    // Reset mid-number discards the partial value.
    put(4); put(2);
    @(negedge clk);
    digit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out", bin_out, 0);
    check("midrst_valid", bin_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send4(5, 6, 7, 8);
    expect_num("n5678", 5678, 0);

`ifdef BCD_RANGE_CHECK_EN
    send4(1, 4'hC, 3, 4);
    expect_num("badbcd", 1034, 1);
    send4(0, 0, 0, 1);
    expect_num("err_cleared", 1, 0);
`endif

    // Back-to-back numbers with digit_valid held high.
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    n_out = 0;
    gaps = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bin_valid && n_out < 4) begin
        outs[n_out] = {18'd0, bin_out};
        n_out++;
      end
      if (!digit_ready) gaps++;
      digit_valid = idx < 8;
      digit_in = idx < 8 ? seq[idx] : 4'd0;
      @(posedge clk);
      if (digit_ready && digit_valid) idx++;
    end
    @(negedge clk);
    digit_valid = 1'b0;
    check("b2b_count", n_out, 2);
    check("b2b_first", outs[0], 1234);
    check("b2b_second", outs[1], 5678);
    check("b2b_gaps", gaps, 2);
    check("b2b_digits", idx, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
